// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and defaults for the UART transmit arbiter
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAIN = 2'd2
    } state_t;
    localparam int TIMEOUT_DEF = 4096;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester bus plus UART transmit handshake for the arbiter
interface uart_tx_arb_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_rdy;
    logic              busy;
    logic              timeout_err;
    modport master (input req, req_data, tx_rdy, output ack, tx_en, tx_data, busy, timeout_err);
    modport slave  (output req, req_data, tx_rdy, input ack, tx_en, tx_data, busy, timeout_err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding one shared UART transmitter
// Grants only when the UART reports idle; an unaccepted tx_en times out and the byte is dropped.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic            clk_50m,
    input logic            rst,
    uart_tx_arb_if.master  bus
);
    localparam int LW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic          rdy_s;
    logic [LW-1:0] last_grant, win, cand;
    logic [LW:0]   sum;
    logic [CW-1:0] cnt;
    logic          found, timeout_hit, launch;

    sync_2ff u_sync (.clk(clk_50m), .rst(rst), .d(bus.tx_rdy), .q(rdy_s));

    // search begins just after the previous winner so every requester gets a turn
    always_comb begin
        win   = last_grant;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum  = {1'b0, last_grant} + (LW+1)'(i);
            cand = (sum >= (LW+1)'(NREQ)) ? LW'(sum - (LW+1)'(NREQ)) : LW'(sum);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE:    if (rdy_s && found) state_n = START;
            START:   if (!rdy_s) state_n = DRAIN;
                     else if (cnt == CW'(TIMEOUT - 1)) begin
                         state_n     = IDLE;
                         timeout_hit = 1'b1;
                     end
            DRAIN:   if (rdy_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign launch = (state == IDLE) && (state_n == START);

    always_ff @(posedge clk_50m or posedge rst)
        if (rst) begin
            state           <= IDLE;
            last_grant      <= LW'(NREQ - 1);
            cnt             <= '0;
            bus.ack         <= '0;
            bus.tx_en       <= 1'b0;
            bus.tx_data     <= 8'h00;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= (state == START && state_n == START) ? cnt + 1'b1 : '0;
            bus.ack         <= launch ? (NREQ'(1) << win) : '0;
            bus.tx_en       <= state_n == START;
            bus.busy        <= state_n != IDLE;
            bus.timeout_err <= bus.timeout_err | timeout_hit;
            if (launch) begin
                last_grant  <= win;
                bus.tx_data <= bus.req_data[{win, 3'b000} +: 8];
            end
        end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized scoreboard bench for the UART transmit arbiter
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int TO   = 32;

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;

    uart_tx_arb_if #(.NREQ(NREQ)) bus ();
    uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (.clk_50m(clk_50m), .rst(rst), .bus(bus));

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } exp_t;

    exp_t       ack_q[$];
    logic [7:0] ser_q[$];
    int         checks = 0, errors = 0;
    int         ptr = NREQ - 1;
    int         cnt[NREQ], served[NREQ];
    logic [7:0] bytes[NREQ][4];
    logic       uart_auto = 1'b0, rdy_force = 1'b0, model_rdy = 1'b1, ack_prev = 1'b0;
    int         phase = 0, u_d = 0, u_l = 0;

    assign bus.tx_rdy = uart_auto ? model_rdy : rdy_force;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: each grant goes to the first pending requester after the previous winner
    task automatic plan_round(input bit serial);
        int   rem[NREQ];
        int   total;
        bit   hit;
        exp_t e;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]    = cnt[i];
            served[i] = 0;
            total    += cnt[i];
        end
        for (int n = 0; n < total; n++) begin
            hit = 0;
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (ptr + k) % NREQ;
                if (!hit && rem[j] > 0) begin
                    hit   = 1;
                    e.idx = j;
                    e.b   = bytes[j][cnt[j] - rem[j]];
                    ack_q.push_back(e);
                    if (serial) ser_q.push_back(e.b);
                    rem[j]--;
                    ptr = j;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]           = cnt[i] > 0;
            bus.req_data[8*i +: 8] = bytes[i][0];
        end
    endtask

    task automatic on_ack();
        for (int i = 0; i < NREQ; i++)
            if (bus.ack[i]) begin
                served[i]++;
                if (served[i] < cnt[i]) bus.req_data[8*i +: 8] = bytes[i][served[i]];
                else bus.req[i] = 1'b0;
            end
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_50m);
            on_ack();
            n++;
        end while (!(bus.req == '0 && !bus.busy && phase == 0 && ack_q.size() == 0) && n < 3000);
        chk("round_completes", n < 3000, 1);
    endtask

    task automatic single(input int i, input logic [7:0] b);
        for (int k = 0; k < NREQ; k++) cnt[k] = 0;
        cnt[i]      = 1;
        bytes[i][0] = b;
    endtask

    // scoreboard monitor for ack pulses
    initial forever begin
        @(negedge clk_50m);
        if (rst) ack_prev = 1'b0;
        else begin
            if (bus.ack != '0) begin
                chk("ack_onehot", 32'($onehot(bus.ack)), 1);
                chk("ack_one_cycle", ack_prev, 0);
                if (ack_q.size() == 0) chk("ack_unexpected", bus.ack, 0);
                else begin
                    exp_t e;
                    e = ack_q.pop_front();
                    chk("ack_winner", bus.ack, 1 << e.idx);
                    chk("grant_byte", bus.tx_data, e.b);
                end
            end
            ack_prev = bus.ack != '0;
        end
    end

    // UART model: accepts tx_en after a short delay, then stays busy for a while
    initial forever begin
        @(negedge clk_50m);
        if (rst || !uart_auto) begin
            phase     = 0;
            model_rdy = 1'b1;
        end else if (phase == 0) begin
            model_rdy = 1'b1;
            if (bus.tx_en) begin
                chk("uart_byte_queued", ser_q.size() != 0, 1);
                if (ser_q.size() != 0) chk("uart_byte", bus.tx_data, ser_q.pop_front());
                u_d   = $urandom_range(0, 3);
                phase = 1;
            end
        end else if (phase == 1) begin
            if (u_d == 0) begin
                model_rdy = 1'b0;
                u_l       = $urandom_range(4, 8);
                phase     = 2;
            end else u_d--;
        end else begin
            if (u_l == 0) begin
                model_rdy = 1'b1;
                phase     = 0;
            end else u_l--;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hi;
        bit seen;
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        repeat (3) @(negedge clk_50m);
        chk("rst_tx_en", bus.tx_en, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        rst       = 1'b0;
        uart_auto = 1'b1;
        repeat (4) @(negedge clk_50m);

        for (int i = 0; i < NREQ; i++) begin
            cnt[i]      = 1;
            bytes[i][0] = 8'h10 + 8'(i);
        end
        plan_round(1);
        run_idle();

        single(0, 8'h41);
        plan_round(1);
        run_idle();

        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        cnt[0] = 3;
        cnt[2] = 3;
        for (int k = 0; k < 3; k++) begin
            bytes[0][k] = 8'($urandom);
            bytes[2][k] = 8'($urandom);
        end
        plan_round(1);
        run_idle();

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) bytes[i][k] = 8'($urandom);
            end
            if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[$urandom_range(0, NREQ-1)] = 2;
            plan_round(1);
            run_idle();
        end

        // acceptance never arrives: tx_en must give up after TO cycles
        rdy_force = 1'b1;
        uart_auto = 1'b0;
        repeat (3) @(negedge clk_50m);
        single(0, 8'h5A);
        plan_round(0);
        n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (!bus.ack[0] && n < 50);
        chk("timeout_grant_seen", bus.ack[0], 1);
        bus.req = '0;
        hi = 0;
        while (bus.tx_en && hi < TO + 10) begin
            hi++;
            @(negedge clk_50m);
        end
        chk("timeout_tx_en_cycles", hi, TO);
        chk("timeout_err_set", bus.timeout_err, 1);
        chk("timeout_busy_low", bus.busy, 0);

        // no grant while the UART reports busy
        rdy_force = 1'b0;
        repeat (4) @(negedge clk_50m);
        single($urandom_range(0, NREQ-1), 8'($urandom));
        plan_round(1);
        seen = 0;
        repeat (5) begin
            @(negedge clk_50m);
            if (bus.ack != '0) seen = 1;
        end
        chk("gated_no_ack", seen, 0);
        rdy_force = 1'b1;
        n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (bus.ack == '0 && n < 20);
        chk("gate_release_latency", n, 3);
        bus.req   = '0;
        uart_auto = 1'b1;
        run_idle();
        chk("timeout_err_sticky", bus.timeout_err, 1);

        // reset while draining
        single($urandom_range(0, NREQ-1), 8'($urandom));
        plan_round(1);
        n = 0;
        do begin
            @(negedge clk_50m);
            if (bus.ack != '0) bus.req = '0;
            n++;
        end while (!(bus.busy && !bus.tx_en && bus.req == '0) && n < 200);
        chk("drain_reached", n < 200, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx_en", bus.tx_en, 0);
        chk("async_rst_ack", bus.ack, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_timeout_err", bus.timeout_err, 0);
        chk("async_rst_tx_data", bus.tx_data, 0);
        ptr = NREQ - 1;
        repeat (3) @(negedge clk_50m);
        single(2, 8'($urandom));
        plan_round(1);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk_50m);
            n++;
        end while (bus.ack == '0 && n < 20);
        chk("post_rst_latency", n, 3);
        bus.req = '0;
        run_idle();

        repeat (5) @(negedge clk_50m);
        chk("ack_queue_empty", ack_q.size(), 0);
        chk("serial_queue_empty", ser_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 4096, SHALL set the maximum clk_50m cycles to wait for UART acceptance of tx_en.
REQ-003 Port clk_50m  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 Port rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port req  input  NREQ  SHALL carry per-requester level "byte pending".
REQ-006 Port req_data  input  NREQ*8  SHALL carry requester i's byte in bits [8i+7:8i].
REQ-007 Port ack  output  NREQ  SHALL give a one-cycle pulse on the requester whose byte was taken.
REQ-008 Port tx_en  output  1  SHALL drive the UART transmit enable.
REQ-009 Port tx_data  output  8  SHALL drive the UART transmit byte.
REQ-010 Port tx_rdy  input  1  SHALL be the UART transmitter-idle flag, asynchronous to clk_50m.
REQ-011 Port busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 Port timeout_err  output  1  SHALL be a sticky flag set on an acceptance timeout.

Function
REQ-013 tx_rdy SHALL pass through a 2-flop synchronizer (reset value 0) before use; the synchronized value is rdy_s.
REQ-014 The FSM SHALL have states IDLE, START and DRAIN.
REQ-015 In IDLE with rdy_s=1 and any req bit high, the block SHALL grant, latch req_data of the winner into tx_data, pulse ack for the winner, and enter START.
REQ-016 All outputs SHALL be registered: req sampled at edge N yields ack and tx_en high from edge N+1.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-018 tx_en SHALL be high exactly while in START; tx_data SHALL hold stable from grant until return to IDLE.
REQ-019 START SHALL exit to DRAIN on the first cycle rdy_s=0, deasserting tx_en in that transition.
REQ-020 DRAIN SHALL exit to IDLE on the first cycle rdy_s=1.
REQ-021 A cycle counter SHALL run in START; when it reaches TIMEOUT-1 with rdy_s still 1, the block SHALL drop tx_en, set timeout_err, and go to IDLE; the byte is lost and no second ack is issued.
REQ-022 ack SHALL be a level-consuming handshake: a requester SHALL drop req or present a new byte on the cycle after ack; a req held high is treated as a new byte.
REQ-023 req changes outside IDLE SHALL be ignored; no grant SHALL occur while rdy_s=0.
REQ-024 At most one ack bit SHALL be high in any cycle; ack SHALL never be high for more than one cycle per grant.
REQ-025 timeout_err SHALL clear only on rst.
REQ-026 Minimum grant-to-grant spacing SHALL be START+DRAIN duration plus 1 IDLE cycle; back-to-back grants from IDLE SHALL be impossible.

Reset
REQ-027 On rst: state=IDLE, tx_en=0, tx_data=8'h00, ack=0, busy=0, timeout_err=0, rdy_s and synchronizer=0, last_grant=NREQ-1, counter=0.
REQ-028 rst asserted mid-transfer SHALL abort immediately, with tx_en low while rst is high; the UART is reset by the same rst.
REQ-029 After rst release, no grant SHALL occur until rdy_s reads 1 (at least 2 cycles).

Structure
REQ-030 The FSM state encoding and the default TIMEOUT SHALL live in shared package uart_pkg.
REQ-031 The synchronizer SHALL be a separate sub-module sync_2ff, reusable for rx_rdy.
REQ-032 Round-robin search, FSM and timeout counter SHALL stay in uart_tx_arb; target size is 120-250 lines.

Verification
REQ-033 Single request: req=4'b0001, req_data[7:0]=8'h41, tx_rdy=1 -> ack=0001 one cycle, tx_en high with tx_data=8'h41 until tx_rdy drops, byte 0x41 seen on uart_txd.
REQ-034 Contention: req=4'b1111 held with bytes 0x10..0x13, each dropped after its ack -> grant order 0,1,2,3; four distinct acks; serial stream 10 11 12 13.
REQ-035 Fairness: req0 and req2 continuously high, re-requesting after each ack -> grants alternate 0,2,0,2; neither starves.
REQ-036 Timeout: tx_rdy forced 1 (UART clock stopped), req=0001 -> tx_en high for exactly TIMEOUT cycles, then low; timeout_err=1 and stays set; busy=0.
REQ-037 Reset mid-transfer: assert rst while in DRAIN -> all outputs return to reset values asynchronously; after release, no ack before 2 cycles with tx_rdy=1.
REQ-038 Gating: tx_rdy=0 at request time -> no ack until 2 cycles after tx_rdy rises.
